// File: rtl/gpio_pad_ctrl_if.sv
// Register-bus bundle for gpio_pad_ctrl: single-cycle write/read strobes,
// 3-bit address and a registered read-data return.
interface gpio_pad_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic             rd_en;
    logic [2:0]       addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;

    modport master (output wr_en, rd_en, addr, wr_data, input rd_data);
    modport slave  (input wr_en, rd_en, addr, wr_data, output rd_data);
endinterface

// File: rtl/gpio_pad_ctrl.sv
// GPIO bank controller: register-driven pad outputs, synchronized edge-detecting inputs.
// Define GPIO_PAD_CTRL_DEBOUNCE_EN to build per-pad debounce counters.

// One pad lane: two-flop synchronizer, optional debounce filter, previous-value flop.
module gpio_pad_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dout,
    output logic filt,
    output logic prev
);
    logic sync1, sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= dout;
            sync2 <= sync1;
            prev  <= filt;
        end
    end

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
    logic [15:0] cnt;

    // Any return to the accepted level restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync2 == filt) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            filt <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end
`else
    wire [31:0] unused_db = 32'(DEBOUNCE_CYCLES);
    assign filt = sync2;
`endif
endmodule

module gpio_pad_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gpio_pad_ctrl_if.slave        bus,
    output logic [WIDTH-1:0]      pad_din,
    output logic [WIDTH-1:0]      pad_oen,
    input  logic [WIDTH-1:0]      pad_dout,
    output logic                  irq
);
    logic [WIDTH-1:0] out_r, oe_r, rise_en, fall_en, pend;
    logic [WIDTH-1:0] filt, prev, set, clr, rd_mux;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_pad_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .dout (pad_dout[i]),
            .filt (filt[i]),
            .prev (prev[i])
        );
    end

    assign set = (filt & ~prev & rise_en) | (~filt & prev & fall_en);
    assign clr = (bus.wr_en && bus.addr == 3'd5) ? bus.wr_data : '0;

    // A new edge overrides a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r   <= '0;
            oe_r    <= '0;
            rise_en <= '0;
            fall_en <= '0;
            pend    <= '0;
        end else begin
            if (bus.wr_en) begin
                case (bus.addr)
                    3'd0:    out_r   <= bus.wr_data;
                    3'd1:    oe_r    <= bus.wr_data;
                    3'd3:    rise_en <= bus.wr_data;
                    3'd4:    fall_en <= bus.wr_data;
                    default: ;
                endcase
            end
            pend <= (pend & ~clr) | set;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            3'd0:    rd_mux = out_r;
            3'd1:    rd_mux = oe_r;
            3'd2:    rd_mux = filt;
            3'd3:    rd_mux = rise_en;
            3'd4:    rd_mux = fall_en;
            3'd5:    rd_mux = pend;
            default: rd_mux = '0;
        endcase
    end

    // Sampled before any same-cycle write lands, so a read-during-write returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bus.rd_data <= '0;
        else if (bus.rd_en)  bus.rd_data <= rd_mux;
    end

    assign pad_din = out_r;
    assign pad_oen = ~oe_r;
    assign irq     = |(pend & (rise_en | fall_en));
endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl; read results are checked through a scoreboard queue.
module tb_gpio_pad_ctrl;
    localparam int W  = 8;
    localparam int DB = 16;
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    localparam int XL = DB;
`else
    localparam int XL = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] pad_din, pad_oen, pad_dout;
    logic         irq;

    gpio_pad_ctrl_if #(.WIDTH(W)) bus ();

    gpio_pad_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .pad_din (pad_din),
        .pad_oen (pad_oen),
        .pad_dout(pad_dout),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] exp;
    } sb_t;
    sb_t sb_q[$];
    int  nvec = 0;
    int  nerr = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        bus.wr_en = 1'b1; bus.addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [W-1:0] e, input string tag);
        sb_t s;
        bus.rd_en = 1'b1; bus.addr = a;
        s.tag = tag; s.exp = e;
        sb_q.push_back(s);
        @(negedge clk);
        bus.rd_en = 1'b0;
        s = sb_q.pop_front();
        chk(s.tag, bus.rd_data, s.exp);
    endtask

    task automatic rdwr(input logic [2:0] a, input logic [W-1:0] d, input logic [W-1:0] e);
        sb_t s;
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.addr = a; bus.wr_data = d;
        s.tag = "rd_during_wr"; s.exp = e;
        sb_q.push_back(s);
        @(negedge clk);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        s = sb_q.pop_front();
        chk(s.tag, bus.rd_data, s.exp);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wr_data = '0;
        pad_dout = '0;

        // Power-on reset state
        cyc(2);
        chk("por_oen", pad_oen, 8'hFF);
        chk("por_din", pad_din, 8'h00);
        chk("por_irq", W'(irq), 8'h00);
        chk("por_rd", bus.rd_data, 8'h00);
        rst_n = 1'b1;
        cyc(1);

        // Build up live state, then reset asynchronously mid-cycle
        wr(3'd1, 8'hFF);
        wr(3'd0, 8'h5A);
        wr(3'd3, 8'h01);
        pad_dout = 8'h01;
        cyc(3 + XL);
        chk("pre_rst_oen", pad_oen, 8'h00);
        chk("pre_rst_irq", W'(irq), 8'h01);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_oen", pad_oen, 8'hFF);
        chk("rst_din", pad_din, 8'h00);
        chk("rst_irq", W'(irq), 8'h00);
        pad_dout = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) rd(3'(a), 8'h00, "rst_reg");

        // Output drive and read-back
        wr(3'd0, 8'hA5);
        wr(3'd1, 8'h0F);
        chk("drv_din", pad_din, 8'hA5);
        chk("drv_oen", pad_oen, 8'hF0);
        rd(3'd1, 8'h0F, "rd_oe");
        cyc(2);
        chk("rd_hold", bus.rd_data, 8'h0F);
        rd(3'd0, 8'hA5, "rd_out");

        // Rising edge: PEND/irq exactly three edges after the pad change
        wr(3'd3, 8'h01);
        pad_dout = 8'h01;
        cyc(2 + XL);
        chk("rise_early_irq", W'(irq), 8'h00);
        cyc(1);
        chk("rise_irq", W'(irq), 8'h01);
        rd(3'd5, 8'h01, "rise_pend");
        rd(3'd2, 8'h01, "rise_in");
        wr(3'd5, 8'h01);
        chk("w1c_irq", W'(irq), 8'h00);

        // Dropping the enable masks irq but keeps PEND
        wr(3'd3, 8'h08);
        pad_dout = 8'h09;
        cyc(3 + XL);
        chk("mask_pre_irq", W'(irq), 8'h01);
        wr(3'd3, 8'h00);
        chk("mask_irq", W'(irq), 8'h00);
        rd(3'd5, 8'h08, "mask_pend");
        wr(3'd5, 8'h08);
        rd(3'd5, 8'h00, "mask_clr");

        // Set-vs-clear collision on bit 1
        wr(3'd3, 8'h02);
        wr(3'd4, 8'h02);
        pad_dout = 8'h0B;
        cyc(3 + XL);
        chk("col_rise_irq", W'(irq), 8'h01);
        pad_dout = 8'h09;
        cyc(2 + XL);
        wr(3'd5, 8'h02);
        chk("col_irq", W'(irq), 8'h01);
        rd(3'd5, 8'h02, "col_pend");
        wr(3'd5, 8'h02);
        chk("col_clr_irq", W'(irq), 8'h00);

        // Edges on disabled bits never record
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h00);
        pad_dout = 8'hFF;
        cyc(4 + XL);
        rd(3'd2, 8'hFF, "dis_in");
        rd(3'd5, 8'h00, "dis_pend");
        chk("dis_irq", W'(irq), 8'h00);
        pad_dout = 8'h00;
        cyc(4 + XL);
        rd(3'd5, 8'h00, "dis_pend_fall");
        rd(3'd2, 8'h00, "dis_in_fall");

        // Read and write together return the old value; unmapped addresses read zero
        rdwr(3'd0, 8'h3C, 8'hA5);
        chk("rdwr_din", pad_din, 8'h3C);
        rd(3'd0, 8'h3C, "rdwr_new");
        wr(3'd6, 8'hFF);
        rd(3'd6, 8'h00, "rd_a6");
        rd(3'd7, 8'h00, "rd_a7");

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
        // Short glitch is filtered, long pulse is accepted
        wr(3'd3, 8'h04);
        pad_dout = 8'h04;
        cyc(10);
        pad_dout = 8'h00;
        cyc(40);
        rd(3'd2, 8'h00, "db_short_in");
        rd(3'd5, 8'h00, "db_short_pend");
        pad_dout = 8'h04;
        cyc(19);
        rd(3'd2, 8'h04, "db_long_in");
        rd(3'd5, 8'h04, "db_long_pend");
        pad_dout = 8'h00;
        cyc(40);
        wr(3'd5, 8'h04);
`endif

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
